sram_d_arbiter: RTL

- 2-to-1 OBI arbiter that drives the SRAM wrapper's data port (sram_d).
- Master 0 is the core LSU data port; master 1 is the secondary data master (debug module / DMA).
- Arbitration is round-robin.
- Requests outside the SRAM window are rejected locally with an error response; they never reach the SRAM.
- A small in-order ID FIFO routes slave responses back to the master that issued each request.

---
 rtl/sram_d_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_d_arbiter.sv
// sram_d_arbiter: round-robin 2:1 OBI arbiter for the SRAM data port.
// Out-of-window requests get a local error; an ID FIFO routes responses.
module sram_d_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR   = 32'h8000_C000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        illegal_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ?
    $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int DEPTH = 1 << PW;
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          id_q [DEPTH];
  logic          rr_q;
  logic          err_pending;

  logic legal0, legal1;
  logic room, empty;
  logic elig0, elig1;
  logic win, win_id, win_legal;
  logic fwd, accept, ill;
  logic push, pop, head;

  assign legal0 = (m0_addr_i >= SRAM_BASE_ADDR) &&
                  (m0_addr_i <  SRAM_END_ADDR);
  assign legal1 = (m1_addr_i >= SRAM_BASE_ADDR) &&
                  (m1_addr_i <  SRAM_END_ADDR);

  assign room  = count < MAXC;
  assign empty = count == '0;

  // Errors wait for an empty FIFO so responses stay in order.
  assign elig0 = !rst_i && m0_req_i && !err_pending &&
                 (legal0 ? room : empty);
  assign elig1 = !rst_i && m1_req_i && !err_pending &&
                 (legal1 ? room : empty);

  assign win       = elig0 | elig1;
  assign win_id    = elig1 && (!elig0 || rr_q);
  assign win_legal = win_id ? legal1 : legal0;

  assign fwd    = win && win_legal;
  assign accept = win && (!win_legal || s_gnt_i);
  assign ill    = win && !win_legal;
  assign push   = fwd && s_gnt_i;
  assign pop    = s_rvalid_i && !empty;
  assign head   = id_q[rd_ptr];

  assign m0_gnt_o = accept && !win_id;
  assign m1_gnt_o = accept && win_id;

  always_comb begin
    s_req_o   = fwd;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (fwd) begin
      if (win_id) begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_addr_o  = m0_addr_i;
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_q[wr_ptr] <= win_id;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rr_q        <= 1'b0;
      err_pending <= 1'b0;
      illegal_o   <= 1'b0;
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;
      m1_rdata_o  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (accept) rr_q <= ~win_id;
      err_pending <= ill;
      illegal_o   <= ill;
      m0_rvalid_o <= (ill && !win_id) || (pop && !head);
      m0_err_o    <= ill && !win_id;
      m0_rdata_o  <= (pop && !head) ? s_rdata_i : '0;
      m1_rvalid_o <= (ill && win_id) || (pop && head);
      m1_err_o    <= ill && win_id;
      m1_rdata_o  <= (pop && head) ? s_rdata_i : '0;
    end
  end

`ifndef SYNTHESIS
  a_no_stray_rvalid : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(s_rvalid_i && empty));
`endif

endmodule
